symmetric_fir_line_filter: RTL

//  Parametrised odd-length symmetric 1-D FIR for pixel streams: next generation of the fixed 1-4-6-4-1 core.

---
 rtl/fir_pkg.sv | 45 ++++
 rtl/fir_mac_pipe.sv | 136 +++++++++++++
 rtl/symmetric_fir_line_filter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the symmetric line FIR.
package fir_pkg;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t ST_IDLE  = 2'd0;
    localparam fir_state_t ST_RUN   = 2'd1;
    localparam fir_state_t ST_FLUSH = 2'd2;

    // Number of taps on each side of the centre tap.
    function automatic int tap_half(input int num_taps);
        return (num_taps - 32'sd1) / 32'sd2;
    endfunction

    // Unsigned sum of two mirrored pixels.
    function automatic int preadd_width(input int data_width);
        return data_width + 32'sd1;
    endfunction

    // Signed product of a zero-extended preadd and a signed coefficient.
    function automatic int prod_width(input int data_width, input int coef_width);
        return data_width + coef_width + 32'sd2;
    endfunction

    // Accumulator width, large enough for the sum of all products.
    function automatic int sum_width(input int data_width, input int coef_width,
                                     input int num_taps);
        return data_width + coef_width + $clog2(num_taps) + 32'sd1;
    endfunction

    // Centre coefficient of the identity kernel (unity gain after the shift).
    function automatic int identity_c0(input int shift);
        return 32'sd1 << shift;
    endfunction

    // Half-LSB rounding constant applied before the normalising shift.
    function automatic int round_const(input int shift);
        if (shift > 32'sd0) begin
            return 32'sd1 << (shift - 32'sd1);
        end else begin
            return 32'sd0;
        end
    endfunction

endpackage

// File: rtl/fir_mac_pipe.sv
// Four-stage datapath: preadd, multiply, sum, round/saturate.
// Coefficients are captured with the window so a new line's coefficients
// never leak into results still in flight from the previous line.
module fir_mac_pipe
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TAPS   = 5,
    parameter int COEF_WIDTH = 8,
    parameter int SHIFT      = 4,
    localparam int K         = tap_half(NUM_TAPS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 launch,
    input  logic                                 launch_sol,
    input  logic                                 launch_eol,
    input  logic                                 launch_bypass,
    input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  window,
    input  logic [K:0][COEF_WIDTH-1:0]           coefs,
    output logic [DATA_WIDTH-1:0]                pixel_out,
    output logic                                 valid_out,
    output logic                                 sol_out,
    output logic                                 eol_out
);

    localparam int PW  = preadd_width(DATA_WIDTH);
    localparam int PRW = prod_width(DATA_WIDTH, COEF_WIDTH);
    localparam int SW  = sum_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
    localparam int RW  = SW + 1;
    localparam logic signed [RW-1:0] RND  = RW'(round_const(SHIFT));
    localparam logic signed [RW-1:0] MAXV = RW'((32'sd1 <<< DATA_WIDTH) - 32'sd1);

    // sideband: index 0 = after stage 1, 1 = after stage 2, 2 = after stage 3
    logic [2:0]                   v_pipe_r;
    logic [2:0]                   sol_pipe_r;
    logic [2:0]                   eol_pipe_r;
    logic [2:0]                   byp_pipe_r;
    logic [2:0][DATA_WIDTH-1:0]   ctr_pipe_r;

    logic [PW-1:0]                pre_s   [K+1];
    logic [PW-1:0]                pre1_r  [K+1];
    logic [K:0][COEF_WIDTH-1:0]   coef1_r;
    logic signed [PRW-1:0]        prod_s  [K+1];
    logic signed [PRW-1:0]        prod2_r [K+1];
    logic signed [SW-1:0]         sum_s;
    logic signed [SW-1:0]         sum3_r;
    logic signed [RW-1:0]         rnd_s;
    logic signed [RW-1:0]         shr_s;
    logic [DATA_WIDTH-1:0]        sat_s;

    // Mirror-pair preadds; index 0 carries the centre pixel alone.
    always_comb begin
        pre_s[0] = PW'(window[K]);
        for (int k = 1; k <= K; k++) begin
            pre_s[k] = PW'(window[K-k]) + PW'(window[K+k]);
        end
    end

    // Signed products of the registered preadds and captured coefficients.
    always_comb begin
        for (int k = 0; k <= K; k++) begin
            prod_s[k] = PRW'($signed({1'b0, pre1_r[k]})) * PRW'($signed(coef1_r[k]));
        end
    end

    // Sign-extended accumulation of all products.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int k = 0; k <= K; k++) begin
            sum_s = sum_s + SW'(prod2_r[k]);
        end
    end

    // Round half-up, arithmetic shift, clamp to the unsigned pixel range.
    always_comb begin
        rnd_s = RW'(sum3_r) + RND;
        shr_s = rnd_s >>> SHIFT;
        if (shr_s[RW-1]) begin
            sat_s = {DATA_WIDTH{1'b0}};
        end else if (shr_s > MAXV) begin
            sat_s = {DATA_WIDTH{1'b1}};
        end else begin
            sat_s = shr_s[DATA_WIDTH-1:0];
        end
    end

    // Pipeline registers for data, coefficients and sideband markers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_pipe_r   <= 3'b000;
            sol_pipe_r <= 3'b000;
            eol_pipe_r <= 3'b000;
            byp_pipe_r <= 3'b000;
            ctr_pipe_r <= '0;
            coef1_r    <= '0;
            sum3_r     <= {SW{1'b0}};
            for (int k = 0; k <= K; k++) begin
                pre1_r[k]  <= {PW{1'b0}};
                prod2_r[k] <= {PRW{1'b0}};
            end
        end else begin
            v_pipe_r   <= {v_pipe_r[1:0], launch};
            sol_pipe_r <= {sol_pipe_r[1:0], launch_sol};
            eol_pipe_r <= {eol_pipe_r[1:0], launch_eol};
            byp_pipe_r <= {byp_pipe_r[1:0], launch_bypass};
            ctr_pipe_r <= {ctr_pipe_r[1:0], window[K]};
            coef1_r    <= coefs;
            sum3_r     <= sum_s;
            for (int k = 0; k <= K; k++) begin
                pre1_r[k]  <= pre_s[k];
                prod2_r[k] <= prod_s[k];
            end
        end
    end

    // Output stage: filtered or bypassed centre pixel with its markers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_out <= {DATA_WIDTH{1'b0}};
            valid_out <= 1'b0;
            sol_out   <= 1'b0;
            eol_out   <= 1'b0;
        end else begin
            valid_out <= v_pipe_r[2];
            sol_out   <= v_pipe_r[2] & sol_pipe_r[2];
            eol_out   <= v_pipe_r[2] & eol_pipe_r[2];
            if (v_pipe_r[2]) begin
                pixel_out <= byp_pipe_r[2] ? ctr_pipe_r[2] : sat_s;
            end else begin
                pixel_out <= pixel_out;
            end
        end
    end

endmodule

// File: rtl/symmetric_fir_line_filter.sv
// Line-aware odd-length symmetric FIR: line FSM, replicated-edge window,
// staging/active coefficient banks, feeding the MAC pipeline.
module symmetric_fir_line_filter
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TAPS   = 5,
    parameter int COEF_WIDTH = 8,
    parameter int SHIFT      = 4,
    localparam int K         = tap_half(NUM_TAPS),
    localparam int ADDR_W    = $clog2(K + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  pixel_in,
    input  logic                   valid_in,
    input  logic                   sol_in,
    input  logic                   eol_in,
    output logic                   in_ready,
    input  logic                   bypass,
    input  logic                   coef_we,
    input  logic [ADDR_W-1:0]      coef_addr,
    input  logic [COEF_WIDTH-1:0]  coef_data,
    output logic [DATA_WIDTH-1:0]  pixel_out,
    output logic                   valid_out,
    output logic                   sol_out,
    output logic                   eol_out,
    output logic                   line_err
);

    localparam int JW = $clog2(K + 2);
    localparam logic [JW-1:0] J_MAX      = JW'(K + 1);
    localparam logic [JW-1:0] J_CTR      = JW'(K);
    localparam logic [JW-1:0] FLUSH_LAST = JW'(K - 1);
    localparam logic [COEF_WIDTH-1:0] C0_IDENT = COEF_WIDTH'(identity_c0(SHIFT));
    localparam logic [K:0][COEF_WIDTH-1:0] COEF_IDENT = {{(K*COEF_WIDTH){1'b0}}, C0_IDENT};

    fir_state_t                          state_r;
    fir_state_t                          state_nxt_s;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win_r;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win_nxt_s;
    logic [JW-1:0]                       j_r;
    logic [JW-1:0]                       j_nxt_s;
    logic [JW-1:0]                       j_inc_s;
    logic [JW-1:0]                       flush_cnt_r;
    logic [JW-1:0]                       flush_nxt_s;
    logic                                xfer_s;
    logic                                shift_s;
    logic                                load_s;
    logic                                err_s;
    logic                                last_flush_s;
    logic                                launch_nxt_s;
    logic                                launch_sol_nxt_s;
    logic                                launch_r;
    logic                                launch_sol_r;
    logic                                launch_eol_r;
    logic                                in_ready_r;
    logic                                line_err_r;
    logic [K:0][COEF_WIDTH-1:0]          stage_coef_r;
    logic [K:0][COEF_WIDTH-1:0]          stage_fwd_s;
    logic [K:0][COEF_WIDTH-1:0]          act_coef_r;
    logic                                bypass_act_r;

    assign xfer_s   = valid_in & in_ready_r;
    // j saturates one past the centre so it never wraps on long lines
    assign j_inc_s  = (j_r == J_MAX) ? j_r : j_r + {{(JW-1){1'b0}}, 1'b1};
    assign in_ready = in_ready_r;
    assign line_err = line_err_r;

    // Line FSM: decides load / shift / flush and the next window contents.
    always_comb begin
        state_nxt_s  = state_r;
        win_nxt_s    = win_r;
        j_nxt_s      = j_r;
        flush_nxt_s  = flush_cnt_r;
        shift_s      = 1'b0;
        load_s       = 1'b0;
        err_s        = 1'b0;
        last_flush_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (sol_in) begin
                        load_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    if (sol_in) begin
                        load_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        shift_s   = 1'b1;
                        win_nxt_s = {win_r[NUM_TAPS-2:0], pixel_in};
                        j_nxt_s   = j_inc_s;
                        if (eol_in) begin
                            state_nxt_s = ST_FLUSH;
                            flush_nxt_s = {JW{1'b0}};
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                shift_s   = 1'b1;
                win_nxt_s = {win_r[NUM_TAPS-2:0], win_r[0]};
                j_nxt_s   = j_inc_s;
                if (flush_cnt_r == FLUSH_LAST) begin
                    last_flush_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    flush_nxt_s  = {JW{1'b0}};
                end else begin
                    flush_nxt_s = flush_cnt_r + {{(JW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (load_s) begin
            win_nxt_s   = {NUM_TAPS{pixel_in}};
            j_nxt_s     = {JW{1'b0}};
            flush_nxt_s = {JW{1'b0}};
            state_nxt_s = eol_in ? ST_FLUSH : ST_RUN;
        end else begin
            win_nxt_s = win_nxt_s;
        end
        launch_nxt_s     = shift_s & (j_nxt_s >= J_CTR);
        launch_sol_nxt_s = shift_s & (j_nxt_s == J_CTR);
    end

    // Staging bank with same-cycle write forwarding into a sol load.
    always_comb begin
        stage_fwd_s = stage_coef_r;
        if (coef_we && (coef_addr <= ADDR_W'(K))) begin
            stage_fwd_s[coef_addr] = coef_data;
        end else begin
            stage_fwd_s = stage_coef_r;
        end
    end

    // State, window, counters, launch sideband and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            win_r        <= '0;
            j_r          <= {JW{1'b0}};
            flush_cnt_r  <= {JW{1'b0}};
            launch_r     <= 1'b0;
            launch_sol_r <= 1'b0;
            launch_eol_r <= 1'b0;
            in_ready_r   <= 1'b1;
            line_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            win_r        <= win_nxt_s;
            j_r          <= j_nxt_s;
            flush_cnt_r  <= flush_nxt_s;
            launch_r     <= launch_nxt_s;
            launch_sol_r <= launch_sol_nxt_s;
            launch_eol_r <= last_flush_s;
            in_ready_r   <= (state_nxt_s != ST_FLUSH);
            line_err_r   <= err_s;
        end
    end

    // Coefficient banks and bypass; active copies change only at a line start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_coef_r <= COEF_IDENT;
            act_coef_r   <= COEF_IDENT;
            bypass_act_r <= 1'b0;
        end else begin
            stage_coef_r <= stage_fwd_s;
            if (load_s) begin
                act_coef_r   <= stage_fwd_s;
                bypass_act_r <= bypass;
            end else begin
                act_coef_r   <= act_coef_r;
                bypass_act_r <= bypass_act_r;
            end
        end
    end

    fir_mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .COEF_WIDTH (COEF_WIDTH),
        .SHIFT      (SHIFT)
    ) u_mac (
        .clk           (clk),
        .reset_n       (reset_n),
        .launch        (launch_r),
        .launch_sol    (launch_sol_r),
        .launch_eol    (launch_eol_r),
        .launch_bypass (bypass_act_r),
        .window        (win_r),
        .coefs         (act_coef_r),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out),
        .sol_out       (sol_out),
        .eol_out       (eol_out)
    );

endmodule
